// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: d = a - b - b_in, one bit per clock, with a
// start/busy/done handshake and a per-bit borrow vector for display.
module serial_subtractor #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic [W-1:0] b_out,
    output logic         ovf
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [CNT_W-1:0]   cnt;
    logic               br;

    logic               a_bit;
    logic               b_bit;
    logic               br_next;
    logic               last_bit;
    logic               accept;

    // Bit-slice arithmetic for the bit currently addressed by the counter.
    always_comb begin
        a_bit    = a_reg[cnt];
        b_bit    = b_reg[cnt];
        br_next  = (~a_bit & b_bit) | (~a_bit & br) | (b_bit & br);
        last_bit = (cnt == CNT_W'(W - 1));
        accept   = (state == IDLE) && start;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operands are captured on acceptance so the inputs may change while busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            d     <= '0;
            b_out <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            cnt   <= '0;
            br    <= b_in;
            d     <= '0;
            b_out <= '0;
            ovf   <= 1'b0;
        end else if (state == SHIFT) begin
            d[cnt]     <= a_bit ^ b_bit ^ br;
            b_out[cnt] <= br_next;
            br         <= br_next;
            // The counter parks at W-1; the final borrow pairs with bit W-2's.
            if (last_bit) begin
                ovf <= br_next ^ b_out[W-2];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (W=4): latency, results,
// ignored restarts, back-to-back starts and asynchronous abort.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic [W-1:0] b_out;
    logic         ovf;

    int n_checks;
    int n_fail;

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .resetn(resetn),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation: start sampled at the next rising edge, then wait for done.
    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic bini, input logic [W-1:0] exp_d,
                          input logic [W-1:0] exp_bout, input logic exp_ovf);
        int cycles;
        @(negedge clk);
        a = ai; b = bi; b_in = bini; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ai; b = ~bi; b_in = ~bini;
        check({tag, ".busy_after_start"}, busy, 1'b1);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, ".latency"}, cycles, W);
        check({tag, ".busy_at_done"}, busy, 1'b1);
        check({tag, ".d"}, d, exp_d);
        check({tag, ".b_out"}, b_out, exp_bout);
        check({tag, ".ovf"}, ovf, exp_ovf);
        @(negedge clk);
        check({tag, ".done_single"}, done, 1'b0);
        check({tag, ".idle_after"}, busy, 1'b0);
        @(negedge clk);
        check({tag, ".d_hold"}, d, exp_d);
    endtask

    initial begin
        int dones;
        n_checks = 0;
        n_fail   = 0;
        resetn = 1'b0;
        start  = 1'b0;
        a = '0; b = '0; b_in = 1'b0;
        #1;
        check("reset.busy",  busy,  1'b0);
        check("reset.done",  done,  1'b0);
        check("reset.d",     d,     4'b0000);
        check("reset.b_out", b_out, 4'b0000);
        check("reset.ovf",   ovf,   1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op("case1", 4'b0101, 4'b0011, 1'b0, 4'b0010, 4'b0010, 1'b0);
        run_op("case2", 4'b0011, 4'b0101, 1'b0, 4'b1110, 4'b1100, 1'b0);
        run_op("case3", 4'b0000, 4'b0000, 1'b1, 4'b1111, 4'b1111, 1'b0);
        run_op("case4", 4'b1000, 4'b0001, 1'b0, 4'b0111, 4'b0111, 1'b1);

        // Restart pulse at E2 with new operands must be ignored.
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'b1111; b = 4'b0000; b_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'b1010;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("restart.done_count", dones, 1);
        check("restart.d",     d,     4'b0010);
        check("restart.b_out", b_out, 4'b0010);
        check("restart.busy",  busy,  1'b0);

        // Held-high start: accepted at E0 and again at E6 only.
        a = 4'b1000; b = 4'b0001; b_in = 1'b0; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 6) start = 1'b0;
            if (done) dones++;
        end
        check("b2b.done_count", dones, 2);
        check("b2b.d",   d,   4'b0111);
        check("b2b.ovf", ovf, 1'b1);

        // Asynchronous abort between E2 and E3.
        @(negedge clk);
        a = 4'b0011; b = 4'b0101; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort.partial_d", d, 4'b0010);
        #2;
        resetn = 1'b0;
        #1;
        check("abort.busy",  busy,  1'b0);
        check("abort.done",  done,  1'b0);
        check("abort.d",     d,     4'b0000);
        check("abort.b_out", b_out, 4'b0000);
        check("abort.ovf",   ovf,   1'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("abort.no_done", dones, 0);
        run_op("case3_after_abort", 4'b0000, 4'b0000, 1'b1, 4'b1111, 4'b1111, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
